// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mdu_sequencer
// Purpose  : Iterative signed multiply/divide unit with its own sequencing FSM.
//            Optional macro MDU_EARLY_OUT_EN enables MUL early termination.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div0,
    output logic             overflow
);

    localparam int               CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             state_q;
    logic               op_q;
    logic [WIDTH-1:0]   a_q, b_q, mag_b_q;
    logic [2*WIDTH-1:0] acc_q, mcand_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q, div0_q, ovf_q;
    logic [WIDTH-1:0]   res_lo_q, res_hi_q;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a_d, mag_b_d, rem_sh_d;
    logic [WIDTH:0]     trial_d;
    logic [2*WIDTH-1:0] acc_d, prod_d;
    logic [WIDTH-1:0]   fix_lo_d, fix_hi_d;
    logic               fix_ovf_d, last_d;

    assign sign_a  = a_q[WIDTH-1];
    assign sign_b  = b_q[WIDTH-1];
    // -MIN wraps to the same bit pattern, which read unsigned is 2^(WIDTH-1).
    assign mag_a_d = sign_a ? -a_q : a_q;
    assign mag_b_d = sign_b ? -b_q : b_q;

    // acc_q holds the product for MUL, or {remainder, quotient-shifter} for DIV.
    assign rem_sh_d = acc_q[2*WIDTH-2:WIDTH-1];
    assign trial_d  = {1'b0, rem_sh_d} - {1'b0, mag_b_q};

    always_comb begin
        acc_d = acc_q;
        if (!op_q) begin
            acc_d = acc_q + (mag_b_q[0] ? mcand_q : '0);
        end else if (!trial_d[WIDTH]) begin
            acc_d = {trial_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {rem_sh_d, acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        last_d = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MDU_EARLY_OUT_EN
        if (!op_q && (mag_b_q >> 1) == '0) begin
            last_d = 1'b1;
        end
`endif
    end

    always_comb begin
        prod_d    = (sign_a ^ sign_b) ? -acc_q : acc_q;
        fix_lo_d  = prod_d[WIDTH-1:0];
        fix_hi_d  = prod_d[2*WIDTH-1:WIDTH];
        fix_ovf_d = (prod_d[2*WIDTH-1:WIDTH] != {WIDTH{prod_d[WIDTH-1]}});
        if (op_q) begin
            fix_lo_d  = (sign_a ^ sign_b) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            fix_hi_d  = sign_a ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            fix_ovf_d = (a_q == C_MIN) && (b_q == '1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
            if (flush) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            op_q <= op;
                            a_q  <= a;
                            b_q  <= b;
                            if (op && b == '0) begin
                                state_q  <= S_DONE;
                                done_q   <= 1'b1;
                                div0_q   <= 1'b1;
                                res_lo_q <= '1;
                                res_hi_q <= a;
                            end else begin
                                state_q <= S_PREP;
                            end
                        end
                    end
                    S_PREP: begin
                        acc_q   <= op_q ? {{WIDTH{1'b0}}, mag_a_d} : '0;
                        mcand_q <= {{WIDTH{1'b0}}, mag_a_d};
                        mag_b_q <= mag_b_d;
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                    end
                    S_RUN: begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (!op_q) begin
                            mcand_q <= mcand_q << 1;
                            mag_b_q <= mag_b_q >> 1;
                        end
                        if (last_d) begin
                            state_q <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        res_lo_q <= fix_lo_d;
                        res_hi_q <= fix_hi_d;
                        ovf_q    <= fix_ovf_d;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign stall     = (start && state_q == S_IDLE) || (busy && state_q != S_DONE);
    assign done      = done_q;
    assign div0      = div0_q;
    assign overflow  = ovf_q;
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_sequencer
// Purpose  : Self-checking bench for mdu_sequencer against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        flush = 1'b0;
    logic        busy, stall, done, div0, overflow;
    logic [15:0] result_lo, result_hi;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] last_lo = '0;
    logic [15:0] last_hi = '0;

    mdu_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .stall(stall), .done(done),
        .result_lo(result_lo), .result_hi(result_hi),
        .div0(div0), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain signed integer arithmetic (SV / and % truncate toward zero).
    task automatic model(input logic o, input logic [15:0] va, input logic [15:0] vb,
                         output logic [15:0] lo, output logic [15:0] hi,
                         output logic d0, output logic ov, output int lat);
        int sa, sb, p, q, r, m, nb;
        sa = $signed(va);
        sb = $signed(vb);
        d0 = 1'b0;
        ov = 1'b0;
        lat = 19;
        if (!o) begin
            p  = sa * sb;
            lo = p[15:0];
            hi = p[31:16];
            ov = (p > 32767) || (p < -32768);
`ifdef MDU_EARLY_OUT_EN
            m  = (sb < 0) ? -sb : sb;
            nb = 0;
            while (m > 0) begin
                nb++;
                m = m >> 1;
            end
            lat = 3 + ((nb < 1) ? 1 : nb);
`endif
        end else if (vb == 16'h0000) begin
            lo  = 16'hFFFF;
            hi  = va;
            d0  = 1'b1;
            lat = 1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[15:0];
            hi = r[15:0];
            ov = (q > 32767);
        end
    endtask

    // Runs one op. restart_cyc >= 0 injects an ignored second start in that cycle.
    task automatic run_op(input string tag, input logic o, input logic [15:0] va,
                          input logic [15:0] vb, input int restart_cyc);
        logic [15:0] e_lo, e_hi;
        logic        e_d0, e_ov, seen, stall_ok;
        int          e_lat, lat;
        model(o, va, vb, e_lo, e_hi, e_d0, e_ov, e_lat);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        #1 check_eq({tag, ":stall_c0"}, stall, 1);
        seen = 1'b0; stall_ok = 1'b1; lat = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(posedge clk); #1;
            start = (c == restart_cyc);
            op = $urandom_range(0, 1);
            a = $urandom; b = $urandom;
            #1;
            if (done) begin
                seen = 1'b1;
                lat  = c;
            end else if (!stall || !busy) begin
                stall_ok = 1'b0;
            end
        end
        check_eq({tag, ":done_seen"}, seen, 1);
        check_eq({tag, ":stall_busy"}, stall_ok, 1);
        check_eq({tag, ":latency"}, lat, e_lat);
        check_eq({tag, ":lo"}, result_lo, e_lo);
        check_eq({tag, ":hi"}, result_hi, e_hi);
        check_eq({tag, ":flags"}, {div0, overflow}, {e_d0, e_ov});
        check_eq({tag, ":stall_done"}, stall, 0);
        // A start in the DONE cycle must not be queued.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check_eq({tag, ":after"}, {done, busy, div0, overflow}, 4'b0000);
        check_eq({tag, ":hold"}, {result_hi, result_lo}, {e_hi, e_lo});
        last_lo = e_lo;
        last_hi = e_hi;
    endtask

    task automatic flush_test(input logic o, input logic [15:0] va, input logic [15:0] vb);
        logic seen_done;
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check_eq("flush:busy_c6", busy, 0);
        seen_done = done;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            seen_done = seen_done | done | div0 | overflow;
        end
        check_eq("flush:no_done", seen_done, 0);
        check_eq("flush:results_kept", {result_hi, result_lo}, {last_hi, last_lo});
    endtask

    initial begin
        logic o;
        logic [15:0] va, vb;
        logic [15:0] corners [5];
        corners[0] = 16'h0000; corners[1] = 16'h0001; corners[2] = 16'hFFFF;
        corners[3] = 16'h8000; corners[4] = 16'h7FFF;

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset:ctrl", {busy, stall, done, div0, overflow}, 5'b00000);
        check_eq("reset:results", {result_hi, result_lo}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        run_op("mul_3_m4",    1'b0, 16'h0003, 16'hFFFC, -1);
        run_op("mul_ovf",     1'b0, 16'h0100, 16'h0100, -1);
        run_op("div_m7_2",    1'b1, 16'hFFF9, 16'h0002, -1);
        run_op("div_min_m1",  1'b1, 16'h8000, 16'hFFFF, -1);
        run_op("div0",        1'b1, 16'h0005, 16'h0000, -1);
        run_op("mul_3_2",     1'b0, 16'h0003, 16'h0002, -1);
        run_op("mul_b0",      1'b0, 16'h1234, 16'h0000, -1);
        run_op("mul_restart", 1'b0, 16'h0007, 16'h0005, 3);
        run_op("div_restart", 1'b1, 16'h0064, 16'hFFF9, 3);

        flush_test(1'b0, 16'h1111, 16'h0022);

        // flush together with start in IDLE: not accepted
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 1'b1; a = 16'h0005; b = 16'h0000;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        #1;
        check_eq("flush_start:busy", {busy, done, div0}, 3'b000);

        // Asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h0123; b = 16'h0456;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst:ctrl", {busy, stall, done, div0, overflow}, 5'b00000);
        check_eq("async_rst:results", {result_hi, result_lo}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        last_lo = '0;
        last_hi = '0;

        for (int i = 0; i < 60; i++) begin
            o  = $urandom_range(0, 1);
            va = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
            vb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
            run_op($sformatf("rnd%0d", i), o, va, vb, (i % 5 == 0) ? 2 : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative signed multiply/divide unit with its own sequencing FSM, for ops too wide for the single-cycle ALU.
- Accepts one operation from the execute stage and holds the pipeline with `stall` while it runs.
- Returns the product, or the quotient and remainder, with a one-cycle `done`.
- Raises `div0` / `overflow` so the main control decoder can halt the system.

Parameters:
- WIDTH, 16, operand/result width in bits (two's complement).

Ports:
- clk  in  1  system clock, rising edge; single clock domain
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = MUL, 1 = DIV
- a  in  WIDTH  multiplicand / dividend (signed)
- b  in  WIDTH  multiplier / divisor (signed)
- flush  in  1  synchronous abort from pipeline flush
- busy  out  1  state != IDLE
- stall  out  1  (start & IDLE) | (busy & state != DONE); combinational
- done  out  1  one-cycle pulse, results valid
- result_lo  out  WIDTH  MUL: product[WIDTH-1:0]; DIV: quotient
- result_hi  out  WIDTH  MUL: product[2*WIDTH-1:WIDTH]; DIV: remainder
- div0  out  1  divide-by-zero flag, asserted with done only
- overflow  out  1  overflow flag, asserted with done only

Behaviour:
- Reset (rst_n low, any time, including mid-operation):
  - state = IDLE.
  - busy, done, div0, overflow, result_lo and result_hi all 0.
- FSM states: IDLE, PREP, RUN, FIX, DONE.
- IDLE:
  - On start & !flush: capture op, a, b; record sign_a, sign_b.
  - If op = DIV and b = 0, go to DONE; otherwise go to PREP.
  - Accept edge = edge E0.
- PREP: convert captured operands to magnitudes (|x|, with -2^(WIDTH-1) mapping to the unsigned 2^(WIDTH-1)); clear the iteration counter.
- RUN: exactly WIDTH iterations, one per cycle, with a log2(WIDTH)+1-bit counter.
  - MUL: shift-add on a 2*WIDTH-bit accumulator, LSB-first over |b|.
  - DIV: restoring division producing an unsigned quotient and remainder.
- FIX: apply signs.
  - MUL: product negated if sign_a ^ sign_b.
  - DIV: quotient negated if sign_a ^ sign_b; remainder takes sign of dividend (truncating division).
  - Load result_lo / result_hi; compute overflow.
- DONE: done = 1 for one cycle, then IDLE. Flags are valid this cycle only and are 0 in every other cycle.
- Latency:
  - Normal: done is asserted in cycle WIDTH+3 after E0 (19 for WIDTH=16).
  - div0 path: done in cycle 1 after E0.
- Overflow conditions:
  - MUL: result_hi is not the sign-extension of result_lo[WIDTH-1].
  - DIV: a = -2^(WIDTH-1) and b = -1; result_lo = 0x8000, result_hi = 0.
- div0 result: div0 = 1, result_lo = all ones, result_hi = a.
- result_lo / result_hi hold their value until the next FIX or div0 DONE load. They are unchanged by flush.
- start while busy, or in the DONE cycle: ignored, no queuing. A new start is accepted at the earliest in the IDLE cycle after DONE.
- flush:
  - Highest priority over start; in any state, next state = IDLE.
  - No done and no flags for the aborted op.
  - In IDLE, flush & start means the start is not accepted.
- stall is deasserted in the DONE cycle so the writeback of results proceeds that cycle.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined (MUL only):
  - RUN performs at least one iteration.
  - After each iteration, if the remaining (shifted) |b| is zero, the next state is FIX.
  - MUL latency = 3 + number of significant bits of |b| (minimum 4).
  - DIV is unchanged.
- Undefined: always exactly WIDTH RUN iterations; latency is fixed.

Test Plan:
- MUL a=0x0003, b=0xFFFC (-4): stall high cycles 0-18, done at cycle 19 → result_lo=0xFFF4, result_hi=0xFFFF, overflow=0.
- MUL a=0x0100, b=0x0100 → result_lo=0x0000, result_hi=0x0001, overflow=1 with done.
- DIV a=0xFFF9 (-7), b=0x0002 → result_lo=0xFFFD, result_hi=0xFFFF, done at cycle 19. Repeat with a=0x8000, b=0xFFFF → result_lo=0x8000, result_hi=0x0000, overflow=1.
- DIV a=0x0005, b=0x0000 → done and div0 at cycle 1, result_lo=0xFFFF, result_hi=0x0005, overflow=0.
- Aborts and reset:
  - start MUL, second start at cycle 3 with different operands → ignored, first result returned.
  - flush at cycle 5 → busy=0 at cycle 6, no done, results keep prior values.
  - rst_n low at cycle 8 → all outputs 0 immediately.
- MDU_EARLY_OUT_EN defined, MUL a=0x0003, b=0x0002 → done at cycle 5, result_lo=0x0006. Undefined → done at cycle 19, same result.
